// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//
// Serial parity checker for framed bit streams. A frame is WIDTH data bits
// followed by one parity bit. The block keeps a running parity of the data
// bits, checks the parity bit against the even/odd mode captured with the
// first data bit, and counts failing frames. The error counter saturates.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       synchronous active-low reset
//   in_valid    qualifies in_bit
//   in_bit      serial bit (data or parity by position in frame)
//   odd_mode    0 = even parity, 1 = odd parity (captured at bit 0)
//   out_bit     running parity of the data bits consumed so far
//   bit_idx     position of the next expected bit (WIDTH = parity slot)
//   frame_done  one-cycle pulse after a parity bit is consumed
//   parity_err  result of the last completed frame
//   err_count   number of failed frames, saturating at all-ones
//
// State table:
//   S_DATA   | consuming data bits, bit_idx = 0..WIDTH-1
//   S_PARITY | waiting for the parity bit, bit_idx = WIDTH

module parity_frame_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic                           in_bit,
    input  logic                           odd_mode,
    output logic                           out_bit,
    output logic [$clog2(WIDTH+1)-1:0]     bit_idx,
    output logic                           frame_done,
    output logic                           parity_err,
    output logic [CNT_W-1:0]               err_count
);

    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        S_DATA   = 1'b0,
        S_PARITY = 1'b1
    } state_t;

    state_t             state_q;
    logic               acc_q;
    logic               odd_q;
    logic [IDX_W-1:0]   idx_q;
    logic               done_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               err_d;
    logic               cnt_full;

    // A frame fails when data parity, parity bit and mode do not cancel out.
    always_comb begin
        err_d = acc_q ^ in_bit ^ odd_q;
    end

    assign cnt_full = &cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_DATA;
            acc_q   <= 1'b0;
            odd_q   <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    S_DATA: begin
                        acc_q <= acc_q ^ in_bit;
                        idx_q <= idx_q + IDX_W'(1);
                        // Mode is frozen for the whole frame at its first bit.
                        if (idx_q == '0) begin
                            odd_q <= odd_mode;
                        end
                        if (idx_q == LAST_DATA_IDX) begin
                            state_q <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        err_q  <= err_d;
                        done_q <= 1'b1;
                        if (err_d && !cnt_full) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        acc_q   <= 1'b0;
                        idx_q   <= '0;
                        state_q <= S_DATA;
                    end
                    default: begin
                        state_q <= S_DATA;
                    end
                endcase
            end
        end
    end

    assign out_bit    = acc_q;
    assign bit_idx    = idx_q;
    assign frame_done = done_q;
    assign parity_err = err_q;
    assign err_count  = cnt_q;

endmodule
